// File: rtl/micro_pkg.sv
// Shared types for the multi-cycle MIPS control sequencer: micro-state encoding,
// opcode/funct constants, ALU function codes and the microword layout.
package micro_pkg;

   localparam int unsigned STATE_W = 4;
   localparam int unsigned OP_W    = 6;
   localparam int unsigned FN_W    = 6;
   localparam int unsigned ALU_W   = 3;

   typedef enum logic [STATE_W-1:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_RTEXEC = 4'd6,
      S_RTWB   = 4'd7,
      S_BEQ    = 4'd8,
      S_J      = 4'd9,
      S_ADDIEX = 4'd10,
      S_ADDIWB = 4'd11
   } state_e;

   localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
   localparam logic [OP_W-1:0] OP_LW    = 6'h23;
   localparam logic [OP_W-1:0] OP_SW    = 6'h2B;
   localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
   localparam logic [OP_W-1:0] OP_J     = 6'h02;
   localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;

   localparam logic [FN_W-1:0] FN_ADD = 6'h20;
   localparam logic [FN_W-1:0] FN_SUB = 6'h22;
   localparam logic [FN_W-1:0] FN_AND = 6'h24;
   localparam logic [FN_W-1:0] FN_OR  = 6'h25;
   localparam logic [FN_W-1:0] FN_NOR = 6'h27;
   localparam logic [FN_W-1:0] FN_SLT = 6'h2A;

   localparam logic [ALU_W-1:0] ALU_ADD = 3'b010;
   localparam logic [ALU_W-1:0] ALU_SUB = 3'b110;
   localparam logic [ALU_W-1:0] ALU_AND = 3'b000;
   localparam logic [ALU_W-1:0] ALU_OR  = 3'b001;
   localparam logic [ALU_W-1:0] ALU_NOR = 3'b011;
   localparam logic [ALU_W-1:0] ALU_SLT = 3'b111;

   localparam logic [1:0] SRCB_B      = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef enum logic [1:0] {
      NS_SEQ      = 2'd0,
      NS_DISPATCH = 2'd1,
      NS_FETCH    = 2'd2
   } next_sel_e;

   // wait_mem: state stalls on mem_ready and its completion strobes are gated by it
   typedef struct packed {
      logic             pc_write;
      logic             pc_write_cond;
      logic             iord;
      logic             mem_read;
      logic             mem_write;
      logic             ir_write;
      logic             reg_dst;
      logic             mem_to_reg;
      logic             reg_write;
      logic             alu_src_a;
      logic [1:0]       alu_src_b;
      logic [1:0]       pc_source;
      logic [ALU_W-1:0] alu_ctrl;
      logic             instr_done;
      logic             alu_by_funct;
      logic             wait_mem;
   } uword_t;

   // Returns {valid, alu_code}; unsupported funct yields {0, ADD}
   function automatic logic [ALU_W:0] funct_decode(input logic [FN_W-1:0] fn);
      case (fn)
         FN_ADD:  return {1'b1, ALU_ADD};
         FN_SUB:  return {1'b1, ALU_SUB};
         FN_AND:  return {1'b1, ALU_AND};
         FN_OR:   return {1'b1, ALU_OR};
         FN_NOR:  return {1'b1, ALU_NOR};
         FN_SLT:  return {1'b1, ALU_SLT};
         default: return {1'b0, ALU_ADD};
      endcase
   endfunction

endpackage

// File: rtl/micro_seq_if.sv
// Datapath-facing signal bundle of the control sequencer.
interface micro_seq_if;
   import micro_pkg::*;

   logic [OP_W-1:0]    opcode;
   logic [FN_W-1:0]    funct;
   logic               zf;
   logic               mem_ready;
   logic               pc_en;
   logic               iord;
   logic               mem_read;
   logic               mem_write;
   logic               ir_write;
   logic               reg_dst;
   logic               mem_to_reg;
   logic               reg_write;
   logic               alu_src_a;
   logic [1:0]         alu_src_b;
   logic [1:0]         pc_source;
   logic [ALU_W-1:0]   alu_ctrl;
   logic [STATE_W-1:0] state;
   logic               instr_done;
   logic               illegal;
   logic               mem_timeout;

   modport master (
      input  opcode, funct, zf, mem_ready,
      output pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
             reg_write, alu_src_a, alu_src_b, pc_source, alu_ctrl, state,
             instr_done, illegal, mem_timeout
   );

   modport slave (
      output opcode, funct, zf, mem_ready,
      input  pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
             reg_write, alu_src_a, alu_src_b, pc_source, alu_ctrl, state,
             instr_done, illegal, mem_timeout
   );

endinterface

// File: rtl/micro_rom.sv
// Control store: maps a micro-state to its microword and next-state select.
module micro_rom
   import micro_pkg::*;
(
   input  state_e    state,
   output uword_t    uword_c,
   output next_sel_e next_sel_c
);

   always_comb begin
      uword_c    = '0;
      next_sel_c = NS_FETCH;
      case (state)
         S_FETCH: begin
            uword_c.mem_read  = 1'b1;
            uword_c.ir_write  = 1'b1;
            uword_c.pc_write  = 1'b1;
            uword_c.alu_src_b = SRCB_FOUR;
            uword_c.pc_source = PCSRC_ALU;
            uword_c.alu_ctrl  = ALU_ADD;
            uword_c.wait_mem  = 1'b1;
            next_sel_c        = NS_SEQ;
         end
         S_DECODE: begin
            uword_c.alu_src_b = SRCB_IMM_SH;
            uword_c.alu_ctrl  = ALU_ADD;
            next_sel_c        = NS_DISPATCH;
         end
         S_MEMADR: begin
            uword_c.alu_src_a = 1'b1;
            uword_c.alu_src_b = SRCB_IMM;
            uword_c.alu_ctrl  = ALU_ADD;
            next_sel_c        = NS_DISPATCH;
         end
         S_MEMRD: begin
            uword_c.mem_read = 1'b1;
            uword_c.iord     = 1'b1;
            uword_c.wait_mem = 1'b1;
            next_sel_c       = NS_SEQ;
         end
         S_MEMWB: begin
            uword_c.reg_write  = 1'b1;
            uword_c.mem_to_reg = 1'b1;
            uword_c.instr_done = 1'b1;
         end
         S_MEMWR: begin
            uword_c.mem_write  = 1'b1;
            uword_c.iord       = 1'b1;
            uword_c.instr_done = 1'b1;
            uword_c.wait_mem   = 1'b1;
         end
         S_RTEXEC: begin
            uword_c.alu_src_a    = 1'b1;
            uword_c.alu_src_b    = SRCB_B;
            uword_c.alu_ctrl     = ALU_ADD;
            uword_c.alu_by_funct = 1'b1;
            next_sel_c           = NS_SEQ;
         end
         S_RTWB: begin
            uword_c.reg_write  = 1'b1;
            uword_c.reg_dst    = 1'b1;
            uword_c.instr_done = 1'b1;
         end
         S_BEQ: begin
            uword_c.alu_src_a     = 1'b1;
            uword_c.alu_src_b     = SRCB_B;
            uword_c.alu_ctrl      = ALU_SUB;
            uword_c.pc_write_cond = 1'b1;
            uword_c.pc_source     = PCSRC_ALUOUT;
            uword_c.instr_done    = 1'b1;
         end
         S_J: begin
            uword_c.pc_write   = 1'b1;
            uword_c.pc_source  = PCSRC_JUMP;
            uword_c.instr_done = 1'b1;
         end
         S_ADDIEX: begin
            uword_c.alu_src_a = 1'b1;
            uword_c.alu_src_b = SRCB_IMM;
            uword_c.alu_ctrl  = ALU_ADD;
            next_sel_c        = NS_SEQ;
         end
         S_ADDIWB: begin
            uword_c.reg_write  = 1'b1;
            uword_c.instr_done = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/micro_seq.sv
// Microprogrammed sequencer for the multi-cycle MIPS datapath: state register,
// opcode/funct dispatch, memory-wait counter and reset-gated Moore outputs.
module micro_seq
   import micro_pkg::*;
#(
   parameter int unsigned WAIT_MAX = 15
) (
   input  logic       clk,
   input  logic       rst,
   micro_seq_if.master bus
);

   localparam int unsigned CNT_W = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic             mem_timeout_q, mem_timeout_d;

   uword_t           rom_c;
   next_sel_e        nsel_c;
   logic             hold_c;
   logic             illegal_c;
   logic             en_c;
   logic             done_en_c;
   logic [ALU_W:0]   fdec_c;

   micro_rom u_rom (
      .state      (state_q),
      .uword_c    (rom_c),
      .next_sel_c (nsel_c)
   );

   assign hold_c    = rom_c.wait_mem & ~bus.mem_ready;
   assign fdec_c    = funct_decode(bus.funct);
   assign en_c      = ~rst;
   assign done_en_c = en_c & ~hold_c;

   // Next-state selection; illegal R-type funct is caught here rather than in RTEXEC
   always_comb begin
      state_d   = state_q;
      illegal_c = 1'b0;
      case (nsel_c)
         NS_SEQ: begin
            if (!hold_c) state_d = state_e'(state_q + STATE_W'(1));
         end
         NS_FETCH: begin
            if (!hold_c) state_d = S_FETCH;
         end
         NS_DISPATCH: begin
            if (state_q == S_MEMADR) begin
               state_d = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end else begin
               case (bus.opcode)
                  OP_RTYPE: begin
                     if (fdec_c[ALU_W]) begin
                        state_d = S_RTEXEC;
                     end else begin
                        state_d   = S_FETCH;
                        illegal_c = 1'b1;
                     end
                  end
                  OP_LW, OP_SW: state_d = S_MEMADR;
                  OP_BEQ:       state_d = S_BEQ;
                  OP_J:         state_d = S_J;
                  OP_ADDI:      state_d = S_ADDIEX;
                  default: begin
                     state_d   = S_FETCH;
                     illegal_c = 1'b1;
                  end
               endcase
            end
         end
         default: state_d = S_FETCH;
      endcase
   end

   // Wait counter restarts on every state change; timeout is sticky until reset
   always_comb begin
      wait_cnt_d    = wait_cnt_q;
      mem_timeout_d = mem_timeout_q;
      if (state_d != state_q) begin
         wait_cnt_d = '0;
      end else if (hold_c) begin
         if (wait_cnt_q != CNT_W'(WAIT_MAX)) wait_cnt_d = wait_cnt_q + CNT_W'(1);
         if ((32'(wait_cnt_q) + 32'd1) >= WAIT_MAX) mem_timeout_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_FETCH;
         wait_cnt_q    <= '0;
         mem_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         wait_cnt_q    <= wait_cnt_d;
         mem_timeout_q <= mem_timeout_d;
      end
   end

   // Moore decode, forced to zero while reset is held
   assign bus.pc_en       = (done_en_c & rom_c.pc_write) | (en_c & rom_c.pc_write_cond & bus.zf);
   assign bus.ir_write    = done_en_c & rom_c.ir_write;
   assign bus.instr_done  = done_en_c & rom_c.instr_done;
   assign bus.iord        = en_c & rom_c.iord;
   assign bus.mem_read    = en_c & rom_c.mem_read;
   assign bus.mem_write   = en_c & rom_c.mem_write;
   assign bus.reg_dst     = en_c & rom_c.reg_dst;
   assign bus.mem_to_reg  = en_c & rom_c.mem_to_reg;
   assign bus.reg_write   = en_c & rom_c.reg_write;
   assign bus.alu_src_a   = en_c & rom_c.alu_src_a;
   assign bus.alu_src_b   = en_c ? rom_c.alu_src_b : 2'b00;
   assign bus.pc_source   = en_c ? rom_c.pc_source : 2'b00;
   assign bus.alu_ctrl    = !en_c ? ALU_W'(0) :
                            (rom_c.alu_by_funct ? fdec_c[ALU_W-1:0] : rom_c.alu_ctrl);
   assign bus.state       = en_c ? STATE_W'(state_q) : STATE_W'(0);
   assign bus.illegal     = en_c & illegal_c;
   assign bus.mem_timeout = en_c & mem_timeout_q;

endmodule

// File: tb/tb_micro_seq.sv
// Scoreboard bench for micro_seq: a behavioural model queues per-cycle inputs and
// expected outputs, which are replayed against the DUT and compared.
module tb_micro_seq;

   localparam int unsigned WAIT_MAX = 7;

   typedef struct packed {
      logic [3:0] state;
      logic       pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
      logic [1:0] alu_src_b, pc_source;
      logic [2:0] alu_ctrl;
      logic       instr_done, illegal, mem_timeout;
   } obs_t;

   typedef struct {
      logic       rst, rdy, zf;
      logic [5:0] op, fn;
      obs_t       exp;
   } cyc_t;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_errors = 0;
   int   m_state, m_cnt;
   logic m_to;
   cyc_t q[$];

   micro_seq_if bus ();

   micro_seq #(.WAIT_MAX(WAIT_MAX)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic fn_ok(input logic [5:0] fn);
      return fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25 || fn == 6'h27 || fn == 6'h2A;
   endfunction

   function automatic logic op_ok(input logic [5:0] op, input logic [5:0] fn);
      if (op == 6'h00) return fn_ok(fn);
      return op == 6'h23 || op == 6'h2B || op == 6'h04 || op == 6'h02 || op == 6'h08;
   endfunction

   function automatic logic [2:0] alu_of(input logic [5:0] fn);
      case (fn)
         6'h22:   return 3'b110;
         6'h24:   return 3'b000;
         6'h25:   return 3'b001;
         6'h27:   return 3'b011;
         6'h2A:   return 3'b111;
         default: return 3'b010;
      endcase
   endfunction

   function automatic obs_t model_out(input int st, input cyc_t c, input logic to);
      obs_t o;
      o = '0;
      if (c.rst) return o;
      o.state       = 4'(st);
      o.mem_timeout = to;
      case (st)
         0: begin o.mem_read = 1; o.alu_src_b = 2'b01; o.alu_ctrl = 3'b010; o.ir_write = c.rdy; o.pc_en = c.rdy; end
         1: begin o.alu_src_b = 2'b11; o.alu_ctrl = 3'b010; o.illegal = !op_ok(c.op, c.fn); end
         2: begin o.alu_src_a = 1; o.alu_src_b = 2'b10; o.alu_ctrl = 3'b010; end
         3: begin o.mem_read = 1; o.iord = 1; end
         4: begin o.reg_write = 1; o.mem_to_reg = 1; o.instr_done = 1; end
         5: begin o.mem_write = 1; o.iord = 1; o.instr_done = c.rdy; end
         6: begin o.alu_src_a = 1; o.alu_ctrl = alu_of(c.fn); end
         7: begin o.reg_write = 1; o.reg_dst = 1; o.instr_done = 1; end
         8: begin o.alu_src_a = 1; o.alu_ctrl = 3'b110; o.pc_source = 2'b01; o.pc_en = c.zf; o.instr_done = 1; end
         9: begin o.pc_en = 1; o.pc_source = 2'b10; o.instr_done = 1; end
         10: begin o.alu_src_a = 1; o.alu_src_b = 2'b10; o.alu_ctrl = 3'b010; end
         11: begin o.reg_write = 1; o.instr_done = 1; end
         default: ;
      endcase
      return o;
   endfunction

   function automatic int model_next(input int st, input cyc_t c);
      case (st)
         0: return c.rdy ? 1 : 0;
         1: begin
            if (!op_ok(c.op, c.fn)) return 0;
            case (c.op)
               6'h00:        return 6;
               6'h23, 6'h2B: return 2;
               6'h04:        return 8;
               6'h02:        return 9;
               default:      return 10;
            endcase
         end
         2: return (c.op == 6'h2B) ? 5 : 3;
         3: return c.rdy ? 4 : 3;
         5: return c.rdy ? 0 : 5;
         6: return 7;
         10: return 11;
         default: return 0;
      endcase
   endfunction

   task automatic model_step(input cyc_t c);
      int nxt;
      if (c.rst) begin
         m_state = 0; m_cnt = 0; m_to = 1'b0;
      end else begin
         nxt = model_next(m_state, c);
         if ((m_state == 0 || m_state == 3 || m_state == 5) && !c.rdy) begin
            if (m_cnt < int'(WAIT_MAX)) m_cnt++;
            if (m_cnt >= int'(WAIT_MAX)) m_to = 1'b1;
         end
         if (nxt != m_state) m_cnt = 0;
         m_state = nxt;
      end
   endtask

   function automatic obs_t sample();
      obs_t o;
      o.state = bus.state;       o.pc_en = bus.pc_en;         o.iord = bus.iord;
      o.mem_read = bus.mem_read; o.mem_write = bus.mem_write; o.ir_write = bus.ir_write;
      o.reg_dst = bus.reg_dst;   o.mem_to_reg = bus.mem_to_reg; o.reg_write = bus.reg_write;
      o.alu_src_a = bus.alu_src_a; o.alu_src_b = bus.alu_src_b; o.pc_source = bus.pc_source;
      o.alu_ctrl = bus.alu_ctrl; o.instr_done = bus.instr_done; o.illegal = bus.illegal;
      o.mem_timeout = bus.mem_timeout;
      return o;
   endfunction

   // Replay queued cycles; exp_cycles >= 0 also checks the cycle of first done/illegal
   task automatic drain(input string name, input int exp_cycles);
      int   cyc = 0;
      int   act = -1;
      cyc_t c;
      obs_t o;
      while (q.size() > 0) begin
         c = q.pop_front();
         @(negedge clk);
         rst = c.rst; bus.mem_ready = c.rdy; bus.zf = c.zf; bus.opcode = c.op; bus.funct = c.fn;
         #1;
         o = sample();
         chk($sformatf("%s_c%0d_s%0d", name, cyc, c.exp.state), 32'(o), 32'(c.exp));
         cyc++;
         if (act < 0 && (o.instr_done || o.illegal)) act = cyc;
      end
      if (exp_cycles >= 0) chk({name, "_cycles"}, 32'(act), 32'(exp_cycles));
   endtask

   task automatic do_reset(input int n);
      cyc_t c;
      for (int i = 0; i < n; i++) begin
         c.rst = 1'b1; c.rdy = 1'b0; c.zf = 1'b0; c.op = 6'h00; c.fn = 6'h20;
         c.exp = model_out(m_state, c, m_to);
         q.push_back(c);
         model_step(c);
      end
      drain("reset", -1);
   endtask

   task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                            input logic zf, input int fw, input int mw, input int rst_at,
                            input int exp_cycles);
      int   n = 0, fcnt = 0, mcnt = 0;
      logic done = 1'b0;
      cyc_t c;
      while (!done && n < 64) begin
         c.op = op; c.fn = fn; c.zf = zf;
         c.rst = (rst_at >= 0) && (n == rst_at || n == rst_at + 1);
         if (m_state == 0) begin
            c.rdy = (fcnt >= fw); fcnt++;
         end else if (m_state == 3 || m_state == 5) begin
            c.rdy = (mcnt >= mw); mcnt++;
         end else begin
            c.rdy = 1'($urandom_range(0, 1));
         end
         c.exp = model_out(m_state, c, m_to);
         q.push_back(c);
         model_step(c);
         n++;
         if (c.rst) done = (n == rst_at + 2);
         else if (c.exp.instr_done || c.exp.illegal) done = 1'b1;
      end
      drain(name, exp_cycles);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; bus.mem_ready = 1'b0; bus.zf = 1'b0; bus.opcode = 6'h00; bus.funct = 6'h20;
      m_state = 0; m_cnt = 0; m_to = 1'b0;
      do_reset(2);

      run_instr("add",  6'h00, 6'h20, 1'b0, 0, 0, -1, 4);
      run_instr("sub",  6'h00, 6'h22, 1'b0, 0, 0, -1, 4);
      run_instr("and",  6'h00, 6'h24, 1'b0, 0, 0, -1, 4);
      run_instr("or",   6'h00, 6'h25, 1'b0, 0, 0, -1, 4);
      run_instr("nor",  6'h00, 6'h27, 1'b0, 0, 0, -1, 4);
      run_instr("slt",  6'h00, 6'h2A, 1'b0, 0, 0, -1, 4);
      run_instr("beq1", 6'h04, 6'h00, 1'b1, 0, 0, -1, 3);
      run_instr("beq0", 6'h04, 6'h00, 1'b0, 0, 0, -1, 3);
      run_instr("j",    6'h02, 6'h00, 1'b0, 0, 0, -1, 3);
      run_instr("addi", 6'h08, 6'h00, 1'b0, 0, 0, -1, 4);
      run_instr("lw",   6'h23, 6'h00, 1'b0, 0, 0, -1, 5);
      run_instr("lw_w", 6'h23, 6'h00, 1'b0, 0, 3, -1, 8);
      run_instr("sw",   6'h2B, 6'h00, 1'b0, 0, 0, -1, 4);
      run_instr("sw_w", 6'h2B, 6'h00, 1'b0, 0, 2, -1, 6);
      run_instr("lw_fw", 6'h23, 6'h00, 1'b0, 2, 0, -1, 7);
      run_instr("ill_op", 6'h3F, 6'h00, 1'b0, 0, 0, -1, 2);
      run_instr("ill_fn", 6'h00, 6'h01, 1'b0, 0, 0, -1, 2);
      run_instr("tmo",  6'h00, 6'h20, 1'b0, int'(WAIT_MAX) + 2, 0, -1, 4 + int'(WAIT_MAX) + 2);
      run_instr("tmo_sticky", 6'h02, 6'h00, 1'b0, 0, 0, -1, 3);
      do_reset(1);
      run_instr("sw_rst", 6'h2B, 6'h00, 1'b0, 0, 10, 5, -1);
      run_instr("after_rst", 6'h08, 6'h00, 1'b0, 0, 0, -1, 4);

      for (int i = 0; i < 20; i++) begin
         int         k, fw, mw, base;
         logic [5:0] op, fn;
         logic       uses_mem;
         k = int'($urandom_range(0, 5));
         fw = int'($urandom_range(0, 3));
         mw = int'($urandom_range(0, 3));
         uses_mem = 1'b0;
         case (k)
            0:       begin op = 6'h23; base = 5; uses_mem = 1'b1; end
            1:       begin op = 6'h2B; base = 4; uses_mem = 1'b1; end
            2:       begin op = 6'h00; base = 4; end
            3:       begin op = 6'h08; base = 4; end
            4:       begin op = 6'h04; base = 3; end
            default: begin op = 6'h02; base = 3; end
         endcase
         case ($urandom_range(0, 5))
            0:       fn = 6'h20;
            1:       fn = 6'h22;
            2:       fn = 6'h24;
            3:       fn = 6'h25;
            4:       fn = 6'h27;
            default: fn = 6'h2A;
         endcase
         run_instr($sformatf("rnd%0d", i), op, fn, 1'($urandom_range(0, 1)), fw, mw, -1,
                   base + fw + (uses_mem ? mw : 0));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
